// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave bit engine: FSM states, default
// address width and the TMP10x sensor address.
package i2c_pkg;

  localparam int ADDRESSLENGTH_DEFAULT = 7;
  localparam logic [6:0] TMP10X_ADDR = 7'h48;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    WAIT_STOP
  } state_t;

endpackage

// File: rtl/i2c_slave_bit_engine_if.sv
// Bus bundle between the bit engine, the raw I2C lines and the memory block.
interface i2c_slave_bit_engine_if #(
  parameter int ADDRESSLENGTH = i2c_pkg::ADDRESSLENGTH_DEFAULT
);
  logic                     scl;
  logic                     sda;
  logic                     sda_oe;
  logic [ADDRESSLENGTH-1:0] direction_buffer;
  logic                     rorw;
  logic [7:0]               input_buffer;
  logic                     enable;
  logic [7:0]               output_buffer;
  logic                     address_found;
  logic                     busy;

  modport slave (
    input  scl, sda, output_buffer, address_found,
    output sda_oe, direction_buffer, rorw, input_buffer, enable, busy
  );

  modport master (
    output scl, sda, output_buffer, address_found,
    input  sda_oe, direction_buffer, rorw, input_buffer, enable, busy
  );
endinterface

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer plus a history flop for one raw I2C line,
// providing the settled level and single-cycle rise/fall strobes.
module i2c_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic hist;

  // Idle bus level is high, so everything resets to 1 to avoid phantom edges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b1;
      sync <= 1'b1;
      hist <= 1'b1;
    end else begin
      meta <= line;
      sync <= meta;
      hist <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~hist;
  assign fall  = ~sync & hist;

endmodule

// File: rtl/i2c_slave_bit_engine.sv
// I2C slave bit engine: tracks START/STOP, shifts address and data bits,
// drives ACK/read data open-drain and handshakes bytes with a memory block.
module i2c_slave_bit_engine
  import i2c_pkg::*;
#(
  parameter int ADDRESSLENGTH = ADDRESSLENGTH_DEFAULT
) (
  input logic                   clk,
  input logic                   rst_n,
  i2c_slave_bit_engine_if.slave bus
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start, stop;
  logic [7:0] new_byte;

  state_t                   state, state_n;
  logic [3:0]               bitcnt, bitcnt_n;
  logic [7:0]               shifter, shifter_n;
  logic                     sda_oe_q, sda_oe_n;
  logic                     enable_q, enable_n;
  logic [ADDRESSLENGTH-1:0] dir_q, dir_n;
  logic                     rorw_q, rorw_n;
  logic [7:0]               inbuf_q, inbuf_n;
  logic                     busy_q, busy_n;
  logic                     load_pend, load_pend_n;
  logic                     wr_pend, wr_pend_n;

  i2c_line_sync u_scl_sync (.clk(clk), .rst_n(rst_n), .line(bus.scl),
                            .level(scl_lvl), .rise(scl_rise), .fall(scl_fall));
  i2c_line_sync u_sda_sync (.clk(clk), .rst_n(rst_n), .line(bus.sda),
                            .level(sda_lvl), .rise(sda_rise), .fall(sda_fall));

  assign start    = sda_fall & scl_lvl;
  assign stop     = sda_rise & scl_lvl;
  assign new_byte = {shifter[6:0], sda_lvl};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      bitcnt    <= '0;
      shifter   <= '0;
      sda_oe_q  <= 1'b0;
      enable_q  <= 1'b0;
      dir_q     <= '0;
      rorw_q    <= 1'b0;
      inbuf_q   <= '0;
      busy_q    <= 1'b0;
      load_pend <= 1'b0;
      wr_pend   <= 1'b0;
    end else begin
      state     <= state_n;
      bitcnt    <= bitcnt_n;
      shifter   <= shifter_n;
      sda_oe_q  <= sda_oe_n;
      enable_q  <= enable_n;
      dir_q     <= dir_n;
      rorw_q    <= rorw_n;
      inbuf_q   <= inbuf_n;
      busy_q    <= busy_n;
      load_pend <= load_pend_n;
      wr_pend   <= wr_pend_n;
    end
  end

  // Memory answers a read Enable within one Clk, so the shifter reloads two
  // Clk after the pulse, well before the next SCL falling edge needs the MSB.
  always_comb begin
    state_n     = state;
    bitcnt_n    = bitcnt;
    shifter_n   = shifter;
    sda_oe_n    = sda_oe_q;
    enable_n    = 1'b0;
    dir_n       = dir_q;
    rorw_n      = rorw_q;
    inbuf_n     = inbuf_q;
    busy_n      = busy_q;
    load_pend_n = enable_q & ~rorw_q;
    wr_pend_n   = 1'b0;

    if (load_pend) shifter_n = bus.output_buffer;
    if (wr_pend)   enable_n  = 1'b1;

    if (start) begin
      state_n  = ADDR;
      bitcnt_n = '0;
      sda_oe_n = 1'b0;
      busy_n   = 1'b1;
    end else if (stop) begin
      state_n  = IDLE;
      bitcnt_n = '0;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else begin
      case (state)
        ADDR: begin
          if (scl_rise && bitcnt < 4'd8) begin
            shifter_n = new_byte;
            bitcnt_n  = bitcnt + 4'd1;
            if (bitcnt == 4'd7) begin
              dir_n  = ADDRESSLENGTH'(new_byte[7:1]);
              rorw_n = ~new_byte[0];
            end
          end else if (scl_fall && bitcnt == 4'd8) begin
            bitcnt_n = '0;
            if (bus.address_found) begin
              state_n  = ADDR_ACK;
              sda_oe_n = 1'b1;
              enable_n = ~rorw_q;
            end else begin
              state_n = WAIT_STOP;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (rorw_q) begin
              state_n  = WR_BYTE;
              sda_oe_n = 1'b0;
            end else begin
              state_n  = RD_BYTE;
              sda_oe_n = ~shifter[7];
            end
          end
        end
        WR_BYTE: begin
          if (scl_rise && bitcnt < 4'd8) begin
            shifter_n = new_byte;
            bitcnt_n  = bitcnt + 4'd1;
            if (bitcnt == 4'd7) begin
              inbuf_n   = new_byte;
              wr_pend_n = 1'b1;
            end
          end else if (scl_fall && bitcnt == 4'd8) begin
            state_n  = WR_ACK;
            sda_oe_n = 1'b1;
            bitcnt_n = '0;
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            state_n  = WR_BYTE;
            sda_oe_n = 1'b0;
          end
        end
        // A falling edge with bitcnt 0 follows a master ACK: drive the fresh MSB.
        RD_BYTE: begin
          if (scl_rise && bitcnt < 4'd8) begin
            bitcnt_n = bitcnt + 4'd1;
          end else if (scl_fall) begin
            if (bitcnt == 4'd0) begin
              sda_oe_n = ~shifter[7];
            end else if (bitcnt == 4'd8) begin
              sda_oe_n = 1'b0;
              state_n  = RD_ACK;
              bitcnt_n = '0;
            end else begin
              shifter_n = {shifter[6:0], 1'b0};
              sda_oe_n  = ~shifter[6];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (!sda_lvl) begin
              enable_n = 1'b1;
              state_n  = RD_BYTE;
            end else begin
              state_n = WAIT_STOP;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sda_oe           = sda_oe_q;
  assign bus.enable           = enable_q;
  assign bus.direction_buffer = dir_q;
  assign bus.rorw             = rorw_q;
  assign bus.input_buffer     = inbuf_q;
  assign bus.busy             = busy_q;

endmodule

// File: doc/i2c_slave_bit_engine.md
I2C_SLAVE_BIT_ENGINE -- requirements
Module: i2c_slave_bit_engine

Interface
REQ-001 SHALL have parameter ADDRESSLENGTH, default 7, the slave address width in bits.
REQ-002 SHALL have one clock; reset is synchronous and active-low.
REQ-003 Clk  in  1  system clock; rising edge only; at least 8x SCL frequency.
REQ-004 Rst_n  in  1  synchronous active-low reset.
REQ-005 Scl  in  1  raw I2C clock line, asynchronous.
REQ-006 Sda  in  1  raw I2C data line, asynchronous.
REQ-007 SdaOe  out  1  1 = pull SDA low (open-drain); 0 = release.
REQ-008 DirectionBuffer  out  ADDRESSLENGTH  received slave address, to the memory block.
REQ-009 RorW  out  1  1 = master writes to slave; 0 = master reads (inverse of I2C R/W bit).
REQ-010 InputBuffer  out  8  last byte received from master.
REQ-011 Enable  out  1  one-Clk pulse requesting a memory transfer.
REQ-012 OutputBuffer  in  8  byte returned by memory after Enable.
REQ-013 AddressFound  in  1  combinational match flag from memory, derived from DirectionBuffer.
REQ-014 Busy  out  1  high from START until STOP or NACK-terminated return to IDLE.

Function
REQ-015 Scl/Sda SHALL pass a 2-flop synchronizer plus one history flop; all decisions use synchronized values and their edges.
REQ-016 START = synchronized SDA falling while SCL high; STOP = SDA rising while SCL high; both are honoured in every state.
REQ-017 States SHALL be IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
REQ-018 START from any state -> ADDR, bit counter cleared (repeated start included); STOP from any state -> IDLE, SdaOe=0.
REQ-019 Bits SHALL be sampled MSB first on SCL rising edges; SdaOe SHALL change only one Clk after an SCL falling edge.
REQ-020 ADDR: after the 8th rising edge, DirectionBuffer <= bits[7:1] and RorW <= ~bit0, in the same Clk.
REQ-021 AddressFound SHALL be sampled at the next SCL falling edge; 1 -> ADDR_ACK with SdaOe=1; 0 -> WAIT_STOP, SdaOe stays 0.
REQ-022 Read address: Enable pulses at the falling edge that enters ADDR_ACK; the shifter loads OutputBuffer 2 Clk later; the ACK is released and the MSB driven at the following falling edge -> RD_BYTE.
REQ-023 Write address: the ACK is released at the falling edge ending ADDR_ACK -> WR_BYTE.
REQ-024 WR_BYTE: after 8 bits, InputBuffer updates; Enable pulses the next Clk; ACK is driven for the 9th clock (WR_ACK), then -> WR_BYTE.
REQ-025 RD_BYTE: SdaOe = ~bit for 8 bits, then released -> RD_ACK.
REQ-026 RD_ACK: master SDA=0 on the 9th rising edge -> Enable pulse, reload shifter 2 Clk later, -> RD_BYTE; SDA=1 (NACK) -> WAIT_STOP.
REQ-027 Bit counter is 4 bits and wraps 0..8 per byte; there is no byte count limit, because memory wrap is owned downstream.
REQ-028 Enable SHALL never be high for more than one consecutive Clk; at most one pulse per byte.

Reset
REQ-029 Rst_n=0 SHALL force IDLE with SdaOe=0, Enable=0, Busy=0, RorW=0, DirectionBuffer=0, InputBuffer=0, shifter=0, counters=0, and synchronizers=1.
REQ-030 Reset mid-transfer SHALL release SDA in the same Clk edge; the block then waits for a fresh START.

Structure
REQ-031 The shared package i2c_pkg SHALL hold the state enum, ADDRESSLENGTH default, and TMP10X_ADDR = 7'h48.
REQ-032 Sub-module i2c_line_sync (synchronizer + rise/fall detect) SHALL be instantiated once each for SCL and SDA.

Verification
REQ-033 START, 0x90 (0x48 W), data 0x60, STOP, AddressFound=1 -> ACK on both bytes, InputBuffer=0x60, RorW=1, one Enable pulse, Busy low after STOP.
REQ-034 START, 0x91, OutputBuffer 0x1A then 0x2B, master ACK then NACK -> SDA carries 0x1A then 0x2B MSB first, exactly 2 Enable pulses, then WAIT_STOP.
REQ-035 START, 0x92 with AddressFound=0 -> SDA released on 9th clock, no Enable, subsequent bytes ignored until STOP.
REQ-036 Write 0x90/0x01, then repeated START 0x91 without STOP -> RorW changes 1->0, read proceeds, no IDLE visit.
REQ-037 Rst_n low during bit 4 of a read byte -> SdaOe=0 next Clk, all outputs reach reset values; a following transaction completes normally.
REQ-038 STOP issued mid-byte in WR_BYTE -> IDLE, no Enable, InputBuffer unchanged.
